// File: rtl/dac_scheduler.sv
// Sample-rate scheduler for a shared SPI DAC driver: snapshots channel A/B at each
// frame tick and issues one or two DAC command words through a start/done handshake.
module dac_scheduler #(
  parameter int unsigned CLK_DIV = 1250,
  parameter logic [3:0]  ADDR_A  = 4'b0000,
  parameter logic [3:0]  ADDR_B  = 4'b0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] sig_a,
  input  logic [11:0] sig_b,
  input  logic        en_a,
  input  logic        en_b,
  input  logic        spi_busy,
  input  logic        spi_done,
  output logic        spi_start,
  output logic [23:0] spi_word,
  output logic        sched_busy,
  output logic        overrun,
  output logic [15:0] frame_count
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  localparam logic [3:0] CMD_WR       = 4'b0000;
  localparam logic [3:0] CMD_WR_UP    = 4'b0011;
  localparam logic [3:0] CMD_WR_UPALL = 4'b0010;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    WAIT_A,
    LOAD_B,
    WAIT_B
  } state_t;

  state_t      state, state_d;
  logic [15:0] div_cnt;
  logic        tick;
  logic [11:0] snap_b;
  logic        lat_en_b;
  logic        snap_load;
  logic        frame_done;
  logic [23:0] word_d;

  assign tick       = (div_cnt == DIV_LAST);
  assign sched_busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  // Channel A's word is built straight from sig_a on the tick; only B needs a
  // held snapshot because its word is formed later, after A's transfer.
  always_comb begin
    state_d    = state;
    snap_load  = 1'b0;
    frame_done = 1'b0;
    spi_start  = 1'b0;
    word_d     = spi_word;
    case (state)
      IDLE: begin
        if (tick) begin
          if (en_a) begin
            state_d   = LOAD_A;
            snap_load = 1'b1;
            word_d    = {(en_b ? CMD_WR : CMD_WR_UP), ADDR_A, sig_a, 4'b0000};
          end else if (en_b) begin
            state_d   = LOAD_B;
            snap_load = 1'b1;
            word_d    = {CMD_WR_UP, ADDR_B, sig_b, 4'b0000};
          end
        end
      end
      LOAD_A: begin
        if (!spi_busy) begin
          spi_start = 1'b1;
          state_d   = WAIT_A;
        end
      end
      WAIT_A: begin
        if (spi_done) begin
          if (lat_en_b) begin
            state_d = LOAD_B;
            word_d  = {CMD_WR_UPALL, ADDR_B, snap_b, 4'b0000};
          end else begin
            state_d    = IDLE;
            frame_done = 1'b1;
          end
        end
      end
      LOAD_B: begin
        if (!spi_busy) begin
          spi_start = 1'b1;
          state_d   = WAIT_B;
        end
      end
      WAIT_B: begin
        if (spi_done) begin
          state_d    = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      spi_word    <= '0;
      snap_b      <= '0;
      lat_en_b    <= 1'b0;
      overrun     <= 1'b0;
      frame_count <= '0;
    end else begin
      state    <= state_d;
      spi_word <= word_d;
      if (snap_load) begin
        snap_b   <= sig_b;
        lat_en_b <= en_b;
      end
      // A tick outside IDLE (including on the final done) is dropped, not queued.
      if (tick && (state != IDLE)) begin
        overrun <= 1'b1;
      end
      if (frame_done) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dac_scheduler.sv
// Directed bench for dac_scheduler: table of frame vectors plus hand-written
// sequences for busy hold-off, overrun and mid-transfer reset.
module tb_dac_scheduler;

  localparam int unsigned DIV = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] sig_a, sig_b;
  logic        en_a, en_b;
  logic        spi_busy, spi_done;
  logic        spi_start;
  logic [23:0] spi_word;
  logic        sched_busy;
  logic        overrun;
  logic [15:0] frame_count;

  dac_scheduler #(.CLK_DIV(DIV), .ADDR_A(4'b0000), .ADDR_B(4'b0001)) dut (
    .clk(clk), .reset(reset), .sig_a(sig_a), .sig_b(sig_b),
    .en_a(en_a), .en_b(en_b), .spi_busy(spi_busy), .spi_done(spi_done),
    .spi_start(spi_start), .spi_word(spi_word), .sched_busy(sched_busy),
    .overrun(overrun), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Returns at the negedge of the cycle where spi_start is seen.
  task automatic wait_start(input int max, output bit found, output int unsigned at);
    found = 1'b0;
    at    = 0;
    for (int i = 0; i < max && !found; i++) begin
      @(negedge clk);
      if (spi_start) begin
        found = 1'b1;
        at    = cyc;
      end
    end
  endtask

  // Emulates the SPI driver: busy after start, done pulse dly cycles later.
  task automatic xfer(input int dly);
    @(posedge clk); #1 spi_busy = 1'b1;
    repeat (dly - 1) @(posedge clk);
    #1 spi_done = 1'b1;
    @(posedge clk); #1;
    spi_done = 1'b0;
    spi_busy = 1'b0;
  endtask

  typedef struct {
    logic        ea, eb;
    logic [11:0] sa, sb;
    bit          drop_b;
    bit          gap;
    int          nstarts;
    logic [23:0] w1, w2;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit          f;
    int unsigned at, last_at;
    int          bad, n;
    logic [15:0] fc_exp;

    vecs[0] = '{1'b1, 1'b0, 12'hABC, 12'h000, 1'b0, 1'b0, 1, 24'h30ABC0, 24'h000000};
    vecs[1] = '{1'b1, 1'b1, 12'h123, 12'h456, 1'b0, 1'b1, 2, 24'h001230, 24'h214560};
    vecs[2] = '{1'b0, 1'b1, 12'h999, 12'h7FF, 1'b0, 1'b1, 1, 24'h317FF0, 24'h000000};
    vecs[3] = '{1'b1, 1'b0, 12'hFFF, 12'h000, 1'b0, 1'b1, 1, 24'h30FFF0, 24'h000000};
    vecs[4] = '{1'b1, 1'b1, 12'h000, 12'hFFF, 1'b0, 1'b1, 2, 24'h000000, 24'h21FFF0};
    vecs[5] = '{1'b0, 1'b0, 12'h555, 12'hAAA, 1'b0, 1'b0, 0, 24'h000000, 24'h000000};
    vecs[6] = '{1'b1, 1'b1, 12'h321, 12'h654, 1'b1, 1'b0, 2, 24'h003210, 24'h216540};

    reset = 1'b0; sig_a = '0; sig_b = '0; en_a = 1'b0; en_b = 1'b0;
    spi_busy = 1'b0; spi_done = 1'b0;
    fc_exp = '0; last_at = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_spi_start", spi_start, 0);
    check("rst_spi_word", spi_word, 0);
    check("rst_sched_busy", sched_busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_count", frame_count, 0);
    reset = 1'b1;

    for (int v = 0; v < 7; v++) begin
      en_a = vecs[v].ea; en_b = vecs[v].eb;
      sig_a = vecs[v].sa; sig_b = vecs[v].sb;
      if (vecs[v].nstarts == 0) begin
        bad = 0;
        repeat (10 * DIV) begin
          @(negedge clk);
          if (spi_start || sched_busy) bad++;
        end
        check($sformatf("v%0d_idle_activity", v), bad, 0);
        check($sformatf("v%0d_frame_count", v), frame_count, fc_exp);
        @(posedge clk); #1;
      end else begin
        wait_start(3 * DIV, f, at);
        check($sformatf("v%0d_start1_seen", v), f, 1);
        if (f) begin
          check($sformatf("v%0d_word1", v), spi_word, vecs[v].w1);
          if (vecs[v].gap) check($sformatf("v%0d_frame_period", v), at - last_at, DIV);
          last_at = at;
          if (vecs[v].drop_b) en_b = 1'b0;
          xfer(20);
          if (vecs[v].nstarts == 2) begin
            wait_start(8, f, at);
            check($sformatf("v%0d_start2_seen", v), f, 1);
            if (f) begin
              check($sformatf("v%0d_word2", v), spi_word, vecs[v].w2);
              xfer(20);
            end
          end
        end
        fc_exp = fc_exp + 16'd1;
        check($sformatf("v%0d_frame_count", v), frame_count, fc_exp);
        check($sformatf("v%0d_sched_idle", v), sched_busy, 0);
      end
    end

    // spi_busy high across LOAD_A entry: start waits, word holds.
    en_a = 1'b1; en_b = 1'b0; sig_a = 12'h5A5; spi_busy = 1'b1;
    f = 1'b0;
    for (int i = 0; i < 3 * DIV && !f; i++) begin
      @(negedge clk);
      if (sched_busy) f = 1'b1;
    end
    check("busy_load_entered", f, 1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (spi_start || spi_word !== 24'h305A50) bad++;
      if (i < 9) @(negedge clk);
    end
    check("busy_hold_violations", bad, 0);
    @(posedge clk); #1 spi_busy = 1'b0;
    @(negedge clk);
    check("busy_release_start", spi_start, 1);
    check("busy_release_word", spi_word, 24'h305A50);
    xfer(20);
    fc_exp = fc_exp + 16'd1;
    check("busy_frame_count", frame_count, fc_exp);

    // done withheld 100 cycles: tick dropped, overrun sticky.
    sig_a = 12'h111;
    check("ovr_clear_before", overrun, 0);
    wait_start(3 * DIV, f, at);
    check("ovr_start_seen", f, 1);
    @(posedge clk); #1 spi_busy = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("ovr_set", overrun, 1);
    check("ovr_frame_pending", frame_count, fc_exp);
    spi_done = 1'b1;
    @(posedge clk); #1;
    spi_done = 1'b0; spi_busy = 1'b0;
    fc_exp = fc_exp + 16'd1;
    check("ovr_frame_count", frame_count, fc_exp);
    check("ovr_idle_after_done", sched_busy, 0);
    wait_start(2 * DIV, f, at);
    check("ovr_next_start_seen", f, 1);
    check("ovr_next_word", spi_word, 24'h301110);
    check("ovr_sticky", overrun, 1);
    xfer(20);

    // Reset asserted while in WAIT_B.
    en_a = 1'b1; en_b = 1'b1; sig_a = 12'h0AA; sig_b = 12'h0BB;
    wait_start(3 * DIV, f, at);
    check("rstb_start_a_seen", f, 1);
    xfer(20);
    wait_start(8, f, at);
    check("rstb_start_b_seen", f, 1);
    check("rstb_word_b", spi_word, 24'h210BB0);
    @(posedge clk); #1 spi_busy = 1'b1;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rstb_spi_start", spi_start, 0);
    check("rstb_spi_word", spi_word, 0);
    check("rstb_sched_busy", sched_busy, 0);
    check("rstb_overrun", overrun, 0);
    check("rstb_frame_count", frame_count, 0);
    spi_busy = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    // Tick while div_cnt==63 (after the 63rd edge); start visible after edge 64.
    f = 1'b0; n = 0;
    for (int i = 1; i <= 3 * DIV && !f; i++) begin
      @(negedge clk);
      if (spi_start) begin
        f = 1'b1;
        n = i;
      end
    end
    check("rstb_first_start_seen", f, 1);
    check("rstb_edges_to_first_start", n - 1, DIV);
    check("rstb_first_word", spi_word, 24'h000AA0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
